// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-look-ahead adder/subtractor with valid/ready handshakes.
// Stage 1 registers bit and group propagate/generate terms; stage 2 resolves the carries and flags.
module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] effb_c, p_c, g_c;
  logic             c0_c;
  logic [NG-1:0]    pg_c, gg_c;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_p_reg, s1_g_reg;
  logic [NG-1:0]    s1_pg_reg, s1_gg_reg;
  logic             s1_c0_reg, s1_amsb_reg, s1_bmsb_reg;

  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;

  logic adv, accept;

  // The output stage frees up when empty or being drained; stage 1 moves with it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = !s1_valid_reg || adv;
  assign accept   = in_valid && in_ready;

  assign effb_c = op[1] ? ~b : b;
  assign c0_c   = op[0] ? cin : op[1];
  assign p_c    = a ^ effb_c;
  assign g_c    = a & effb_c;

  for (genvar gi = 0; gi < NG; gi++) begin : g_s1
    logic gen_l;
    always_comb begin
      logic term;
      gen_l = 1'b0;
      term  = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
        term = g_c[gi*GROUP + j];
        for (int k = j + 1; k < GROUP; k++) term = term & p_c[gi*GROUP + k];
        gen_l = gen_l | term;
      end
    end
    assign pg_c[gi] = &p_c[gi*GROUP +: GROUP];
    assign gg_c[gi] = gen_l;
  end

  // Group carries as flat sum-of-products over the group P/G terms, no inter-group ripple.
  always_comb begin
    logic acc, term;
    grp_c[0] = s1_c0_reg;
    acc      = 1'b0;
    term     = 1'b0;
    for (int k = 1; k <= NG; k++) begin
      acc = s1_c0_reg;
      for (int m = 0; m < k; m++) acc = acc & s1_pg_reg[m];
      for (int j = 0; j < k; j++) begin
        term = s1_gg_reg[j];
        for (int m = j + 1; m < k; m++) term = term & s1_pg_reg[m];
        acc = acc | term;
      end
      grp_c[k] = acc;
    end
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_s2
    logic [GROUP-1:0] cg;
    always_comb begin
      logic acc, term;
      acc  = 1'b0;
      term = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
        acc = grp_c[gi];
        for (int m = 0; m < i; m++) acc = acc & s1_p_reg[gi*GROUP + m];
        for (int j = 0; j < i; j++) begin
          term = s1_g_reg[gi*GROUP + j];
          for (int m = j + 1; m < i; m++) term = term & s1_p_reg[gi*GROUP + m];
          acc = acc | term;
        end
        cg[i] = acc;
      end
    end
    assign sum_c[gi*GROUP +: GROUP] = s1_p_reg[gi*GROUP +: GROUP] ^ cg;
  end

  assign ovf_c = (s1_amsb_reg == s1_bmsb_reg) && (sum_c[WIDTH-1] != s1_amsb_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_p_reg     <= '0;
      s1_g_reg     <= '0;
      s1_pg_reg    <= '0;
      s1_gg_reg    <= '0;
      s1_c0_reg    <= 1'b0;
      s1_amsb_reg  <= 1'b0;
      s1_bmsb_reg  <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_p_reg     <= p_c;
      s1_g_reg     <= g_c;
      s1_pg_reg    <= pg_c;
      s1_gg_reg    <= gg_c;
      s1_c0_reg    <= c0_c;
      s1_amsb_reg  <= a[WIDTH-1];
      s1_bmsb_reg  <= effb_c[WIDTH-1];
    end else if (adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum  <= sum_c;
        cout <= grp_c[NG];
        ovf  <= ovf_c;
        zero <= ~|sum_c;
      end
    end
  end

endmodule
